// File: rtl/ba201_mdu_pkg.sv
// Shared definitions for the RV32M multi-cycle multiply/divide sequencer.
//   XLEN      operand/result width (only 32 is supported)
//   ITER_CNT  CALC iterations per multiply/divide
//   OP_*      funct3 encodings of the M-extension operations
//   state_t   sequencer states
//   neg32     two's-complement negation helper
package ba201_mdu_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned ITER_CNT = 32;
   localparam int unsigned CNT_W    = $clog2(ITER_CNT);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [2:0] {
      IDLE,
      SPECIAL,
      CALC,
      FIX,
      DONE
   } state_t;

   function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] v);
      return ~v + XLEN'(1);
   endfunction

endpackage

// File: rtl/exu_mdu_ctrl_if.sv
// Request/response bundle between the execute stage and the MDU sequencer.
//   mdu_i_req/op/rs1_data/rs2_data/kill : requester -> MDU
//   mdu_o_ready/busy/done/result/illegal : MDU -> requester
// Modports: master (execute stage side), slave (MDU side).
interface exu_mdu_ctrl_if;
   import ba201_mdu_pkg::*;

   logic            mdu_i_req;
   logic [2:0]      mdu_i_op;
   logic [XLEN-1:0] mdu_i_rs1_data;
   logic [XLEN-1:0] mdu_i_rs2_data;
   logic            mdu_i_kill;
   logic            mdu_o_ready;
   logic            mdu_o_busy;
   logic            mdu_o_done;
   logic [XLEN-1:0] mdu_o_result;
   logic            mdu_o_illegal;

   modport master (
      output mdu_i_req, mdu_i_op, mdu_i_rs1_data, mdu_i_rs2_data, mdu_i_kill,
      input  mdu_o_ready, mdu_o_busy, mdu_o_done, mdu_o_result, mdu_o_illegal
   );

   modport slave (
      input  mdu_i_req, mdu_i_op, mdu_i_rs1_data, mdu_i_rs2_data, mdu_i_kill,
      output mdu_o_ready, mdu_o_busy, mdu_o_done, mdu_o_result, mdu_o_illegal
   );

endinterface

// File: rtl/mdu_iter_step.sv
// One combinational iteration of the shift-add multiplier / restoring divider.
//   div_mode : 0 = multiply step, 1 = divide step
//   hi, lo   : multiply: {hi,lo} partial product, lo holds unconsumed multiplier bits
//              divide:   hi = partial remainder, lo = dividend bits / quotient bits
//   m        : multiplicand (multiply) or divisor (divide)
//   hi_nxt, lo_nxt : register pair after this step
module mdu_iter_step
   import ba201_mdu_pkg::*;
(
   input  logic            div_mode,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] m,
   output logic [XLEN-1:0] hi_nxt,
   output logic [XLEN-1:0] lo_nxt
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
      shifted = {hi, lo[XLEN-1]};
      // Partial remainder < divisor, so the 33-bit difference never wraps;
      // its top bit is the borrow that selects restore.
      diff    = shifted - {1'b0, m};
      if (div_mode) begin
         hi_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
         lo_nxt = {lo[XLEN-2:0], ~diff[XLEN]};
      end else begin
         hi_nxt = sum[XLEN:1];
         lo_nxt = {sum[0], lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/exu_mdu_ctrl.sv
// RV32M multi-cycle multiply/divide sequencer beside the execute stage.
// Accepts an op on req & ready, stalls the core via busy, and returns a
// registered result with a one-cycle done pulse.
//   clk  : core clock
//   rst  : asynchronous active-low reset
//   mdu  : exu_mdu_ctrl_if.slave (request, operands, kill, ready/busy/done/result/illegal)
// Build option: BA201_MDU_DIV_EN enables the divider; without it divide ops
// complete through SPECIAL with result 0 and illegal set.
module exu_mdu_ctrl
   import ba201_mdu_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   exu_mdu_ctrl_if.slave mdu
);

   state_t             state_q, state_nxt;
   logic [CNT_W-1:0]   cnt_q;
   logic [2:0]         op_q;
   logic               neg_q;
   logic [XLEN-1:0]    hi_q, lo_q, m_q;
   logic [XLEN-1:0]    result_q;
   logic               done_q, busy_q, illegal_q;
`ifdef BA201_MDU_DIV_EN
   logic               neg_rem_q;
`endif

   logic               accept;
   logic [2:0]         op;
   logic               a_signed, b_signed, s1, s2, is_div, special;
   logic [XLEN-1:0]    abs1, abs2, spec_res;
   logic [XLEN-1:0]    hi_step, lo_step;
   logic               div_mode;
   logic [2*XLEN-1:0]  prod_fix;
   logic [XLEN-1:0]    fix_res;
   logic               illegal_nxt;

   assign mdu.mdu_o_ready   = (state_q == IDLE) && !mdu.mdu_i_kill;
   assign accept            = mdu.mdu_i_req && mdu.mdu_o_ready;
   assign mdu.mdu_o_busy    = busy_q;
   assign mdu.mdu_o_done    = done_q;
   assign mdu.mdu_o_result  = result_q;
   assign mdu.mdu_o_illegal = illegal_q;

   // Operand conditioning at accept: signs, magnitudes and special cases.
   always_comb begin
      op       = mdu.mdu_i_op;
      a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
      b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      s1       = a_signed && mdu.mdu_i_rs1_data[XLEN-1];
      s2       = b_signed && mdu.mdu_i_rs2_data[XLEN-1];
      abs1     = s1 ? neg32(mdu.mdu_i_rs1_data) : mdu.mdu_i_rs1_data;
      abs2     = s2 ? neg32(mdu.mdu_i_rs2_data) : mdu.mdu_i_rs2_data;
      is_div   = op[2];
      special  = 1'b0;
      spec_res = '0;
`ifdef BA201_MDU_DIV_EN
      if (is_div && (mdu.mdu_i_rs2_data == '0)) begin
         special  = 1'b1;
         spec_res = op[1] ? mdu.mdu_i_rs1_data : '1;
      end else if (((op == OP_DIV) || (op == OP_REM)) &&
                   (mdu.mdu_i_rs1_data == 32'h8000_0000) && (mdu.mdu_i_rs2_data == '1)) begin
         special  = 1'b1;
         spec_res = op[1] ? '0 : 32'h8000_0000;
      end
`else
      special  = is_div;
`endif
   end

`ifdef BA201_MDU_DIV_EN
   assign div_mode    = op_q[2];
   assign illegal_nxt = 1'b0;
`else
   assign div_mode    = 1'b0;
   assign illegal_nxt = (state_q == SPECIAL) && op_q[2];
`endif

   mdu_iter_step u_step (
      .div_mode (div_mode),
      .hi       (hi_q),
      .lo       (lo_q),
      .m        (m_q),
      .hi_nxt   (hi_step),
      .lo_nxt   (lo_step)
   );

   // Final sign correction; divide leaves quotient in lo, remainder in hi.
   always_comb begin
      prod_fix = neg_q ? (~{hi_q, lo_q} + 64'd1) : {hi_q, lo_q};
      fix_res  = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`ifdef BA201_MDU_DIV_EN
      if (op_q[2]) begin
         if (op_q[1]) fix_res = neg_rem_q ? neg32(hi_q) : hi_q;
         else         fix_res = neg_q     ? neg32(lo_q) : lo_q;
      end
`endif
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (accept) state_nxt = special ? SPECIAL : CALC;
         SPECIAL: state_nxt = DONE;
         CALC:    if (cnt_q == CNT_W'(ITER_CNT - 1)) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (mdu.mdu_i_kill && (state_q != IDLE)) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         m_q       <= '0;
         result_q  <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         illegal_q <= 1'b0;
`ifdef BA201_MDU_DIV_EN
         neg_rem_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_nxt;
         busy_q    <= (state_nxt != IDLE);
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         if (accept) begin
            op_q  <= op;
            neg_q <= s1 ^ s2;
            cnt_q <= '0;
            hi_q  <= '0;
            m_q   <= is_div ? abs2 : abs1;
            // SPECIAL parks its answer in lo until the DONE transition.
            lo_q  <= special ? spec_res : (is_div ? abs1 : abs2);
`ifdef BA201_MDU_DIV_EN
            neg_rem_q <= s1;
`endif
         end else if (state_q == CALC) begin
            hi_q  <= hi_step;
            lo_q  <= lo_step;
            cnt_q <= cnt_q + CNT_W'(1);
         end
         // Result only moves on a completed op, so a kill leaves it untouched.
         if (state_nxt == DONE) begin
            done_q    <= 1'b1;
            illegal_q <= illegal_nxt;
            result_q  <= (state_q == FIX) ? fix_res : lo_q;
         end
      end
   end

endmodule

// File: tb/tb_exu_mdu_ctrl.sv
module tb_exu_mdu_ctrl;
   import ba201_mdu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   exu_mdu_ctrl_if mif();

   exu_mdu_ctrl dut (
      .clk (clk),
      .rst (rst),
      .mdu (mif)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   // Reference arithmetic straight from the RV32M definitions.
   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, za, zb, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      za = {32'd0, a};
      zb = {32'd0, b};
      p  = '0;
`ifndef BA201_MDU_DIV_EN
      if (op[2]) return 32'd0;
`endif
      case (op)
         OP_MUL:    begin p = za * zb; return p[31:0];  end
         OP_MULH:   begin p = sa * sb; return p[63:32]; end
         OP_MULHSU: begin p = sa * zb; return p[63:32]; end
         OP_MULHU:  begin p = za * zb; return p[63:32]; end
         OP_DIV: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         OP_DIVU: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            p = za / zb; return p[31:0];
         end
         OP_REM: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            p = za % zb; return p[31:0];
         end
      endcase
   endfunction

   // Cycles from accept to the done cycle.
   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!op[2]) return 34;
`ifndef BA201_MDU_DIV_EN
      return 2;
`else
      if (b == 32'd0) return 2;
      if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 34;
`endif
   endfunction

   function automatic logic ref_ill(input logic [2:0] op);
`ifdef BA201_MDU_DIV_EN
      return 1'b0 & op[0];
`else
      return op[2];
`endif
   endfunction

   // Timeline model: m_t counts cycles since accept (0 = idle).
   int          m_t, m_lat;
   logic [31:0] m_res, pend_res;
   logic        m_done, m_ill, pend_ill;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_t <= 0; m_lat <= 34; m_res <= '0; m_done <= 1'b0; m_ill <= 1'b0;
         pend_res <= '0; pend_ill <= 1'b0;
      end else begin
         m_done <= 1'b0;
         m_ill  <= 1'b0;
         if (m_t == 0) begin
            if (mif.mdu_i_req && !mif.mdu_i_kill) begin
               m_t      <= 1;
               m_lat    <= ref_lat(mif.mdu_i_op, mif.mdu_i_rs1_data, mif.mdu_i_rs2_data);
               pend_res <= ref_result(mif.mdu_i_op, mif.mdu_i_rs1_data, mif.mdu_i_rs2_data);
               pend_ill <= ref_ill(mif.mdu_i_op);
            end
         end else if (mif.mdu_i_kill || m_t == m_lat) begin
            m_t <= 0;
         end else begin
            m_t <= m_t + 1;
            if (m_t + 1 == m_lat) begin
               m_done <= 1'b1;
               m_res  <= pend_res;
               m_ill  <= pend_ill;
            end
         end
      end
   end

   // Cycle-by-cycle compare against the model.
   initial begin
      @(posedge rst);
      forever begin
         @(posedge clk); #1;
         chk("busy",    mif.mdu_o_busy,    m_t != 0);
         chk("done",    mif.mdu_o_done,    m_done);
         chk("illegal", mif.mdu_o_illegal, m_ill);
         chk("result",  mif.mdu_o_result,  m_res);
         @(negedge clk);
         chk("ready",   mif.mdu_o_ready,   (m_t == 0) && !mif.mdu_i_kill);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, n_cmp=%0d n_bad=%0d", n_cmp, n_bad);
      $fatal(1);
   end

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      int          lat;
   } vec_t;
   vec_t vq[$];

   task automatic add(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.r = r; v.lat = lat;
      vq.push_back(v);
   endtask

   // Called at posedge+2; returns at posedge+2 of the done cycle.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input int el, input logic eill, input string nm,
                        output int acc1, output int dcyc);
      bit acc;
      int n;
      acc1 = 0; dcyc = 0;
      mif.mdu_i_req = 1'b1; mif.mdu_i_op = op;
      mif.mdu_i_rs1_data = a; mif.mdu_i_rs2_data = b;
      acc = 1'b0; n = 0;
      while (!acc && n < 64) begin
         @(negedge clk); acc = mif.mdu_o_ready;
         @(posedge clk); #2; n++;
      end
      mif.mdu_i_req = 1'b0;
      if (!acc) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_accept: got no accept, expected accept within 64 cycles", nm);
         return;
      end
      acc1 = cyc_cnt;
      n = 1;
      while (!mif.mdu_o_done && n < 100) begin
         @(posedge clk); #2; n++;
      end
      chk({nm, "_lat"},     n,                 el);
      chk({nm, "_res"},     mif.mdu_o_result,  er);
      chk({nm, "_illegal"}, mif.mdu_o_illegal, eill);
      dcyc = cyc_cnt;
   endtask

   initial begin
      logic [31:0] er;
      int          el;
      logic        eill;
      int          acc1, dcyc, c1;
      bit          acc;
      logic [2:0]  kop;

      mif.mdu_i_req = 1'b0; mif.mdu_i_op = '0; mif.mdu_i_kill = 1'b0;
      mif.mdu_i_rs1_data = '0; mif.mdu_i_rs2_data = '0;

      #3;
      chk("rst_busy",    mif.mdu_o_busy,    1'b0);
      chk("rst_done",    mif.mdu_o_done,    1'b0);
      chk("rst_illegal", mif.mdu_o_illegal, 1'b0);
      chk("rst_result",  mif.mdu_o_result,  32'h0);
      chk("rst_ready",   mif.mdu_o_ready,   1'b1);
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b1;

      add(OP_MUL,    32'd7,         32'd6,         32'h0000_002A, 34);
      add(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
      add(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      add(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34);
      add(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34);
      add(OP_MULHU,  32'h8000_0000, 32'd2,         32'h0000_0001, 34);
      add(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
      add(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
      add(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
      add(OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
      add(OP_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 34);
      add(OP_DIV,    32'h8000_0000, 32'd2,         32'hC000_0000, 34);
      add(OP_REMU,   32'd7,         32'd3,         32'h0000_0001, 34);
      add(OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 2);
      add(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);
      add(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
      add(OP_REMU,   32'd9,         32'd0,         32'h0000_0009, 2);
      add(OP_DIVU,   32'd10,        32'd2,         32'h0000_0005, 34);
      add(OP_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34);

      for (int i = 0; i < vq.size(); i++) begin
         er = vq[i].r; el = vq[i].lat; eill = 1'b0;
`ifndef BA201_MDU_DIV_EN
         if (vq[i].op[2]) begin er = 32'd0; el = 2; eill = 1'b1; end
`endif
         do_op(vq[i].op, vq[i].a, vq[i].b, er, el, eill, $sformatf("vec%0d", i), acc1, dcyc);
      end

      // Kill in IDLE blocks the accept.
      mif.mdu_i_req = 1'b1; mif.mdu_i_kill = 1'b1;
      mif.mdu_i_op = OP_MUL; mif.mdu_i_rs1_data = 32'd1; mif.mdu_i_rs2_data = 32'd1;
      @(posedge clk); #2;
      @(negedge clk);
      chk("kill_idle_ready", mif.mdu_o_ready, 1'b0);
      @(posedge clk); #2;
      chk("kill_idle_busy", mif.mdu_o_busy, 1'b0);
      mif.mdu_i_req = 1'b0; mif.mdu_i_kill = 1'b0;

      // Kill mid-operation, then restart in the following cycle.
      do_op(OP_MUL, 32'd7, 32'd6, 32'h0000_002A, 34, 1'b0, "pre_kill", acc1, dcyc);
`ifdef BA201_MDU_DIV_EN
      kop = OP_DIV;
`else
      kop = OP_MULHU;
`endif
      mif.mdu_i_req = 1'b1; mif.mdu_i_op = kop;
      mif.mdu_i_rs1_data = 32'hFFFF_FFF9; mif.mdu_i_rs2_data = 32'd2;
      acc = 1'b0;
      for (int n = 0; n < 64 && !acc; n++) begin
         @(negedge clk); acc = mif.mdu_o_ready;
         @(posedge clk); #2;
      end
      mif.mdu_i_req = 1'b0;
      chk("kill_accept", acc, 1'b1);
      c1 = cyc_cnt;
      repeat (9) begin @(posedge clk); #2; end
      mif.mdu_i_kill = 1'b1;
      @(posedge clk); #2;
      mif.mdu_i_kill = 1'b0;
      chk("kill_busy",   mif.mdu_o_busy,   1'b0);
      chk("kill_done",   mif.mdu_o_done,   1'b0);
      chk("kill_result", mif.mdu_o_result, 32'h0000_002A);
      do_op(OP_MUL, 32'd3, 32'd5, 32'h0000_000F, 34, 1'b0, "post_kill", acc1, dcyc);
      chk("post_kill_done_cycle", dcyc - (c1 - 1), 45);

      @(posedge clk); #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/exu_mdu_ctrl.md
# exu_mdu_ctrl

Multi-cycle sequencer for the RV32M multiply/divide operations that the single-cycle execute stage cannot complete in one cycle. It sits beside the execute unit, takes the same rs1/rs2 operands plus funct3, and runs an iterative shift-add multiplier or restoring divider. While an operation is in flight it holds the core in stall. It returns a registered 32-bit result with a one-cycle done pulse for writeback.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mdu_i_req  in  1  request; the operation is accepted when mdu_i_req & mdu_o_ready.
- mdu_i_op  in  3  funct3: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
- mdu_i_rs1_data  in  32  dividend / multiplicand.
- mdu_i_rs2_data  in  32  divisor / multiplier.
- mdu_i_kill  in  1  pipeline flush; abort any operation.
- mdu_o_ready  out  1  high only in IDLE and only when mdu_i_kill is low (combinational).
- mdu_o_busy  out  1  registered; high whenever state != IDLE; drives core stall.
- mdu_o_done  out  1  one-cycle pulse; result is valid.
- mdu_o_result  out  32  registered result; held from done until the next accept.
- mdu_o_illegal  out  1  pulses with done for a compiled-out divide op.

## Operation
- States:
  - IDLE: on accept → SPECIAL or CALC.
  - SPECIAL: → DONE.
  - CALC: 32 iterations, cycle counter 0..31. Exits to FIX at count 31.
  - FIX: → DONE.
  - DONE: → IDLE.
- Accept latches the op, the operand signs, and the absolute values:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
  - DIV, REM: both operands signed.
  - MUL: sign handling is irrelevant; the low half is identical either way.
- Multiply: 64-bit product register, one shift-add step per CALC cycle.
  - FIX negates the 64-bit product when the operand signs differ.
  - MUL selects the low word; the MULH* ops select the high word.
- Divide: restoring divide, one subtract/shift step per CALC cycle, producing quotient and remainder.
  - FIX negates the quotient when the signs differ (DIV).
  - FIX negates the remainder when the dividend is negative (REM).
- Special cases are resolved at accept and go through SPECIAL, with no CALC:
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- All arithmetic is performed modulo 2^32 or 2^64; there is no trap on overflow.
- Kill:
  - In any state other than IDLE, the next state is IDLE and no done is issued; mdu_o_result keeps its old value.
  - Kill in IDLE blocks the accept in the same cycle, because kill has priority over req.
- Req while busy: ignored, since ready is low; the requester holds req until ready.
- Reset: state IDLE, counter 0, mdu_o_busy 0, mdu_o_done 0, mdu_o_illegal 0, mdu_o_result 0x00000000, internal registers 0.

## Timing
- Accept at edge 0.
- Normal operation:
  - CALC occupies cycles 1–32, FIX cycle 33.
  - DONE is cycle 34, with mdu_o_done = 1 and the result valid.
  - IDLE is cycle 35, and a back-to-back accept is possible in cycle 35.
- Special case: SPECIAL in cycle 1, done in cycle 2.
- mdu_o_busy is high from cycle 1 through the DONE cycle inclusive.
  - The core must stall the accept cycle itself using req & ready.
- Done and result change only on clock edges; there are no combinational paths from the inputs to done or result.

## Configuration
- BA201_MDU_DIV_EN defined: full divide/remainder support as described above.
- BA201_MDU_DIV_EN undefined: divider datapath removed; only MUL* ops are supported.
  - An accepted op 1xx goes to DONE the next cycle.
  - It returns mdu_o_result = 0 with mdu_o_done = 1 and mdu_o_illegal = 1.
  - No CALC cycles are spent.

## Structure
- Shared package ba201_mdu_pkg holds:
  - XLEN;
  - funct3 op constants;
  - state enum (IDLE, SPECIAL, CALC, FIX, DONE);
  - ITER_CNT = 32.
- One sub-module, mdu_iter_step: combinational single iteration, selected by a mul/div mode bit.
  - Multiply: conditional add and shift of the {hi, lo} pair.
  - Divide: trial subtract, restore, and quotient bit.
- Top level holds the FSM, counter, sign latches, FIX negation and output registers.

## Test plan
- MUL 7 × 6 → done at cycle 34 after accept, result 0x0000002A; busy high for cycles 1–34.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000. MULHU with the same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3); REM with the same operands → 0xFFFFFFFF (−1).
- DIVU 5 / 0 → 0xFFFFFFFF and REM 0x80000000 / 0xFFFFFFFF → 0, each with done at cycle 2.
- Kill asserted at cycle 10 of a DIV → IDLE at cycle 11 with no done and the previous result held. A new MUL accepted at cycle 11 → its done at cycle 45.
- BA201_MDU_DIV_EN undefined: DIVU 10 / 2 → done and illegal at cycle 2, result 0.
